svr_rr_arbiter: RTL

SVR_RR_ARBITER -- requirements
Module: svr_rr_arbiter

---
 rtl/svr_rr_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/svr_rr_arbiter.sv
// svr_rr_arbiter: packet-atomic round-robin arbiter that merges NUM_REQ valid/ready
// requester channels onto one registered valid/ready output channel.
module svr_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_valid,
    output logic [NUM_REQ-1:0]            s_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic [ID_WIDTH-1:0]           m_id,
    output logic [NUM_REQ-1:0]            grant
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    logic                  state_r;
    logic [ID_WIDTH-1:0]   ptr_r;
    logic [ID_WIDTH-1:0]   owner_r;
    logic [NUM_REQ-1:0]    grant_r;
    logic                  m_valid_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic                  m_last_r;
    logic [ID_WIDTH-1:0]   m_id_r;

    logic                  pick_found_s;
    logic [ID_WIDTH-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0]    pick_onehot_s;
    logic [NUM_REQ-1:0]    s_ready_s;
    logic                  out_free_s;
    logic                  owner_valid_s;
    logic                  owner_last_s;
    logic [DATA_WIDTH-1:0] owner_data_s;
    logic                  owner_xfer_s;

    // Round-robin search: the winner is the set request with the smallest rotated
    // distance from last_owner+1, so the previous owner is considered last.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [NUM_REQ-1:0]  req,
        input logic [ID_WIDTH-1:0] last_owner
    );
        int                  best_d;
        int                  d;
        logic                take;
        logic [ID_WIDTH-1:0] sel;
        best_d = NUM_REQ;
        sel    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            d      = (j + 2 * NUM_REQ - int'(last_owner) - 1) % NUM_REQ;
            take   = req[j] && (d < best_d);
            sel    = take ? ID_WIDTH'(j) : sel;
            best_d = take ? d : best_d;
        end
        return {(best_d < NUM_REQ), sel};
    endfunction

    // Owner channel selection, ready generation and next-owner search.
    always_comb begin
        {pick_found_s, pick_idx_s} = rr_pick(s_valid, ptr_r);
        out_free_s    = !m_valid_r || m_ready;
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        owner_data_s  = '0;
        s_ready_s     = '0;
        pick_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_valid_s    = (owner_r == ID_WIDTH'(i)) ? s_valid[i] : owner_valid_s;
            owner_last_s     = (owner_r == ID_WIDTH'(i)) ? s_last[i] : owner_last_s;
            owner_data_s     = (owner_r == ID_WIDTH'(i)) ? s_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                         : owner_data_s;
            // ready comes only from registered state and m_ready, never from s_valid
            s_ready_s[i]     = (state_r == STATE_BUSY) && (owner_r == ID_WIDTH'(i)) && out_free_s;
            pick_onehot_s[i] = (pick_idx_s == ID_WIDTH'(i));
        end
        owner_xfer_s = (state_r == STATE_BUSY) && owner_valid_s && out_free_s;
    end

    // Ownership FSM: lock an owner in IDLE, release it only on its last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= STATE_IDLE;
            ptr_r   <= ID_WIDTH'(NUM_REQ - 1);
            owner_r <= '0;
            grant_r <= '0;
        end else begin
            case (state_r)
                STATE_IDLE: begin
                    if (pick_found_s) begin
                        owner_r <= pick_idx_s;
                        grant_r <= pick_onehot_s;
                        state_r <= STATE_BUSY;
                    end else begin
                        grant_r <= '0;
                    end
                end
                STATE_BUSY: begin
                    if (owner_xfer_s && owner_last_s) begin
                        ptr_r   <= owner_r;
                        grant_r <= '0;
                        state_r <= STATE_IDLE;
                    end else begin
                        state_r <= STATE_BUSY;
                    end
                end
                default: begin
                    state_r <= STATE_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Output skid-free register: load on owner transfer, drain on m_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_last_r  <= 1'b0;
            m_id_r    <= '0;
        end else if (owner_xfer_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= owner_data_s;
            m_last_r  <= owner_last_s;
            m_id_r    <= owner_r;
        end else if (m_valid_r && m_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign s_ready = s_ready_s;
    assign grant   = grant_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;
    assign m_id    = m_id_r;

endmodule
